ahb_lite_master: RTL

- Single-master front end that drives the AHB-lite fabric's HADDR/HWRITE/HWDATA and consumes its HRDATA.
- Accepts CPU-side commands (read/write, address, data) on a valid/ready interface and buffers them in a command FIFO.
- Issues each command as a pipelined zero-wait-state AHB-lite transfer: address phase, then data phase.
- Returns read data in order through a response FIFO with backpressure.

---
 rtl/ahb_lite_master.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ahb_lite_master.sv
// AHB-lite single-master front end: command FIFO, pipelined issue, read-response FIFO.
// Ports: HCLK/HRESET, cmd_* (command in), rsp_* (read data out), HADDR/HWRITE/HWDATA/HRDATA, idle.
module ahb_lite_master #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RSP_DEPTH = 4,
    parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    output logic        idle
);

    localparam int CAW  = $clog2(CMD_DEPTH);
    localparam int CCW  = CAW + 1;
    localparam int RAW  = $clog2(RSP_DEPTH);
    localparam int RCW  = RAW + 1;
    localparam int RCW1 = RCW + 1;

    logic            cmd_wr_mem [CMD_DEPTH];
    logic [31:0]     cmd_addr_mem [CMD_DEPTH];
    logic [31:0]     cmd_data_mem [CMD_DEPTH];
    logic [CAW-1:0]  cmd_wptr;
    logic [CAW-1:0]  cmd_rptr;
    logic [CCW-1:0]  cmd_count;
    logic            cmd_push;
    logic            cmd_pop;
    logic            head_write;
    logic [31:0]     head_addr;
    logic [31:0]     head_wdata;

    logic [31:0]     rsp_mem [RSP_DEPTH];
    logic [RAW-1:0]  rsp_wptr;
    logic [RAW-1:0]  rsp_rptr;
    logic [RCW-1:0]  rsp_count;
    logic            rsp_push;
    logic            rsp_pop;

    logic            a_valid;
    logic [31:0]     a_wdata;
    logic            d_valid;
    logic            d_write;
    logic [1:0]      rd_in_flight;
    logic [RCW1-1:0] credit_used;

    assign cmd_ready  = !HRESET && (cmd_count < CCW'(CMD_DEPTH));
    assign cmd_push   = cmd_valid && cmd_ready;
    assign head_write = cmd_wr_mem[cmd_rptr];
    assign head_addr  = cmd_addr_mem[cmd_rptr];
    assign head_wdata = cmd_data_mem[cmd_rptr];

    // Reads still owed a response slot: queued responses plus reads on the bus.
    assign rd_in_flight = 2'(a_valid & ~HWRITE) + 2'(d_valid & ~d_write);
    assign credit_used  = RCW1'(rsp_count) + RCW1'(rd_in_flight);

    assign cmd_pop = (cmd_count != '0) &&
                     (head_write || (credit_used < RCW1'(RSP_DEPTH)));

    assign rsp_push  = d_valid && !d_write;
    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_valid ? rsp_mem[rsp_rptr] : 32'h0;

    assign idle = (cmd_count == '0) && !a_valid && !d_valid && (rsp_count == '0);

    always_ff @(posedge HCLK) begin
        if (cmd_push) begin
            cmd_wr_mem[cmd_wptr]   <= cmd_write;
            cmd_addr_mem[cmd_wptr] <= cmd_addr;
            cmd_data_mem[cmd_wptr] <= cmd_wdata;
        end
        if (rsp_push) begin
            rsp_mem[rsp_wptr] <= HRDATA;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cmd_wptr  <= '0;
            cmd_rptr  <= '0;
            cmd_count <= '0;
        end else begin
            if (cmd_push) cmd_wptr <= cmd_wptr + CAW'(1);
            if (cmd_pop)  cmd_rptr <= cmd_rptr + CAW'(1);
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_count <= cmd_count + CCW'(1);
                2'b01:   cmd_count <= cmd_count - CCW'(1);
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    // Address and data phase registers; an empty slot drives an idle read.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HADDR   <= IDLE_ADDR;
            HWRITE  <= 1'b0;
            a_valid <= 1'b0;
            a_wdata <= 32'h0;
            d_valid <= 1'b0;
            d_write <= 1'b0;
            HWDATA  <= 32'h0;
        end else begin
            if (cmd_pop) begin
                HADDR   <= head_addr & 32'hFFFF_FFFC;
                HWRITE  <= head_write;
                a_valid <= 1'b1;
                a_wdata <= head_write ? head_wdata : 32'h0;
            end else begin
                HADDR   <= IDLE_ADDR;
                HWRITE  <= 1'b0;
                a_valid <= 1'b0;
                a_wdata <= 32'h0;
            end
            d_valid <= a_valid;
            d_write <= HWRITE;
            HWDATA  <= a_wdata;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_wptr  <= '0;
            rsp_rptr  <= '0;
            rsp_count <= '0;
        end else begin
            if (rsp_push && !rsp_pop) begin
                assert (rsp_count < RCW'(RSP_DEPTH));
            end
            if (rsp_push) rsp_wptr <= rsp_wptr + RAW'(1);
            if (rsp_pop)  rsp_rptr <= rsp_rptr + RAW'(1);
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_count <= rsp_count + RCW'(1);
                2'b01:   rsp_count <= rsp_count - RCW'(1);
                default: rsp_count <= rsp_count;
            endcase
        end
    end

endmodule
